// File: rtl/noc_rr_arbiter.sv
// Registered round-robin arbiter with packet lock for the NoC switch allocator.
// One-hot grant is held for a whole packet; the priority pointer rotates past the last winner.
module noc_rr_arbiter #(
    parameter int ARBITER_WIDTH = 4,
    parameter int BIN_WIDTH     = (ARBITER_WIDTH > 2) ? $clog2(ARBITER_WIDTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ARBITER_WIDTH-1:0] request_i,
    input  logic                     release_i,
    input  logic                     en_i,
    output logic [ARBITER_WIDTH-1:0] grant_o,
    output logic [BIN_WIDTH-1:0]     grant_bin_o,
    output logic                     grant_valid_o
);

    localparam int unsigned N = ARBITER_WIDTH;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e               state_q, state_d;
    logic [N-1:0]         grant_q, grant_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BIN_WIDTH-1:0] ptr_q, ptr_d;

    logic [2*N-1:0]       req_dbl;
    logic [N-1:0]         req_rot;
    logic                 found;
    int unsigned          win_int;
    int unsigned          nxt_int;
    logic [BIN_WIDTH-1:0] win_idx;
    logic [BIN_WIDTH-1:0] win_next;
    logic                 pkt_end;
    logic                 do_arb;

    // Rotating the doubled request vector by ptr puts port ptr at bit 0, so the
    // search wraps modulo N rather than modulo 2^BIN_WIDTH.
    always_comb begin
        req_dbl  = {request_i, request_i} >> ptr_q;
        req_rot  = req_dbl[N-1:0];
        found    = 1'b0;
        win_int  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                win_int = 32'(ptr_q) + i;
                if (win_int >= N) begin
                    win_int = win_int - N;
                end
            end
        end
        nxt_int = win_int + 1;
        if (nxt_int >= N) begin
            nxt_int = 0;
        end
        win_idx  = BIN_WIDTH'(win_int);
        win_next = BIN_WIDTH'(nxt_int);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        bin_d   = bin_q;
        ptr_d   = ptr_q;
        pkt_end = release_i || !(|(request_i & grant_q));
        do_arb  = 1'b0;

        unique case (state_q)
            IDLE:   do_arb = en_i && found;
            LOCKED: begin
                if (pkt_end) begin
                    do_arb = en_i && found;
                    if (!do_arb) begin
                        state_d = IDLE;
                        grant_d = '0;
                        bin_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_arb) begin
            state_d = LOCKED;
            grant_d = N'(1) << win_idx;
            bin_d   = win_idx;
            ptr_d   = win_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            bin_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            bin_q   <= bin_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_bin_o   = bin_q;
    assign grant_valid_o = (state_q == LOCKED);

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Scoreboard bench for noc_rr_arbiter: N=4 instance for the main scenarios,
// N=3 instance for the non-power-of-two wrap.
module tb_noc_rr_arbiter;

    typedef struct packed {
        logic [3:0] req;
        logic       rel;
        logic       en;
        logic [3:0] g;
        logic [1:0] b;
    } step_t;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] b;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req4;
    logic [2:0] req3;
    logic       rel;
    logic       en;
    logic [3:0] g4;
    logic [1:0] b4;
    logic       v4;
    logic [2:0] g3;
    logic [1:0] b3;
    logic       v3;

    exp_t        sb_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    noc_rr_arbiter #(.ARBITER_WIDTH(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .request_i    (req4),
        .release_i    (rel),
        .en_i         (en),
        .grant_o      (g4),
        .grant_bin_o  (b4),
        .grant_valid_o(v4)
    );

    noc_rr_arbiter #(.ARBITER_WIDTH(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .request_i    (req3),
        .release_i    (rel),
        .en_i         (en),
        .grant_o      (g3),
        .grant_bin_o  (b3),
        .grant_valid_o(v3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        step_t tbl[$];
        exp_t  e;
        rst_n = 1'b0;
        req4  = 4'b1111;
        req3  = 3'b000;
        rel   = 1'b0;
        en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({g4, b4, v4} !== 7'b0) begin
            bad++;
            $display("FAIL reset_n4 got grant=%b bin=%0d valid=%b want all zero", g4, b4, v4);
        end
        total++;
        if ({g3, b3, v3} !== 6'b0) begin
            bad++;
            $display("FAIL reset_n3 got grant=%b bin=%0d valid=%b want all zero", g3, b3, v3);
        end
        rst_n = 1'b1;
        tbl.push_back('{4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0});
        for (int i = 0; i < tbl.size(); i++) begin
            req4 = tbl[i].req; rel = tbl[i].rel; en = tbl[i].en;
            sb_q.push_back('{tbl[i].g, tbl[i].b, |tbl[i].g});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
                bad++;
                $display("FAIL first_grant[%0d] got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                         i, g4, b4, v4, e.g, e.b, e.v);
            end
        end
    endtask

    task automatic test_rotation();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0});
        for (int i = 0; i < tbl.size(); i++) begin
            req4 = tbl[i].req; rel = tbl[i].rel; en = tbl[i].en;
            sb_q.push_back('{tbl[i].g, tbl[i].b, |tbl[i].g});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
                bad++;
                $display("FAIL rotation[%0d] got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                         i, g4, b4, v4, e.g, e.b, e.v);
            end
        end
    endtask

    task automatic test_lock();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2});
        for (int k = 0; k < 5; k++) tbl.push_back('{4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2});
        tbl.push_back('{4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3});
        for (int i = 0; i < tbl.size(); i++) begin
            req4 = tbl[i].req; rel = tbl[i].rel; en = tbl[i].en;
            sb_q.push_back('{tbl[i].g, tbl[i].b, |tbl[i].g});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
                bad++;
                $display("FAIL lock[%0d] got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                         i, g4, b4, v4, e.g, e.b, e.v);
            end
        end
    endtask

    task automatic test_drop_wrap();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0});
        tbl.push_back('{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0});
        for (int i = 0; i < tbl.size(); i++) begin
            req4 = tbl[i].req; rel = tbl[i].rel; en = tbl[i].en;
            sb_q.push_back('{tbl[i].g, tbl[i].b, |tbl[i].g});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
                bad++;
                $display("FAIL drop_wrap[%0d] got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                         i, g4, b4, v4, e.g, e.b, e.v);
            end
        end
    endtask

    task automatic test_enable();
        step_t tbl[$];
        exp_t  e;
        for (int k = 0; k < 3; k++) tbl.push_back('{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0});
        tbl.push_back('{4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1});
        tbl.push_back('{4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1});
        tbl.push_back('{4'b1111, 1'b0, 1'b0, 4'b0010, 2'd1});
        tbl.push_back('{4'b0010, 1'b1, 1'b0, 4'b0000, 2'd0});
        tbl.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0});
        for (int i = 0; i < tbl.size(); i++) begin
            req4 = tbl[i].req; rel = tbl[i].rel; en = tbl[i].en;
            sb_q.push_back('{tbl[i].g, tbl[i].b, |tbl[i].g});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
                bad++;
                $display("FAIL enable[%0d] got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                         i, g4, b4, v4, e.g, e.b, e.v);
            end
        end
    endtask

    task automatic test_sole_requester();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back('{4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1});
        tbl.push_back('{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1});
        tbl.push_back('{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0});
        for (int i = 0; i < tbl.size(); i++) begin
            req4 = tbl[i].req; rel = tbl[i].rel; en = tbl[i].en;
            sb_q.push_back('{tbl[i].g, tbl[i].b, |tbl[i].g});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
                bad++;
                $display("FAIL sole_requester[%0d] got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                         i, g4, b4, v4, e.g, e.b, e.v);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        req4 = 4'b0010; rel = 1'b0; en = 1'b1;
        sb_q.push_back('{4'b0010, 2'd1, 1'b1});
        @(posedge clk); #1;
        e = sb_q.pop_front();
        total++;
        if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
            bad++;
            $display("FAIL async_pre got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                     g4, b4, v4, e.g, e.b, e.v);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({g4, b4, v4} !== 7'b0) begin
            bad++;
            $display("FAIL async_clear got grant=%b bin=%0d valid=%b want all zero", g4, b4, v4);
        end
        #2;
        req4  = 4'b1111;
        rst_n = 1'b1;
        sb_q.push_back('{4'b0001, 2'd0, 1'b1});
        @(posedge clk); #1;
        e = sb_q.pop_front();
        total++;
        if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
            bad++;
            $display("FAIL async_ptr_zero got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                     g4, b4, v4, e.g, e.b, e.v);
        end
        req4 = 4'b0000; rel = 1'b1;
        sb_q.push_back('{4'b0000, 2'd0, 1'b0});
        @(posedge clk); #1;
        e = sb_q.pop_front();
        total++;
        if ({g4, b4, v4} !== {e.g, e.b, e.v}) begin
            bad++;
            $display("FAIL async_idle got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                     g4, b4, v4, e.g, e.b, e.v);
        end
    endtask

    task automatic test_n3_wrap();
        step_t tbl[$];
        exp_t  e;
        req4 = 4'b0000;
        tbl.push_back('{4'b0111, 1'b1, 1'b1, 4'b0001, 2'd0});
        tbl.push_back('{4'b0111, 1'b1, 1'b1, 4'b0010, 2'd1});
        tbl.push_back('{4'b0111, 1'b1, 1'b1, 4'b0100, 2'd2});
        tbl.push_back('{4'b0111, 1'b1, 1'b1, 4'b0001, 2'd0});
        tbl.push_back('{4'b0111, 1'b1, 1'b1, 4'b0010, 2'd1});
        for (int i = 0; i < tbl.size(); i++) begin
            req3 = tbl[i].req[2:0]; rel = tbl[i].rel; en = tbl[i].en;
            sb_q.push_back('{tbl[i].g, tbl[i].b, |tbl[i].g});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            total++;
            if ({1'b0, g3, b3, v3} !== {e.g, e.b, e.v}) begin
                bad++;
                $display("FAIL n3_wrap[%0d] got grant=%b bin=%0d valid=%b want grant=%b bin=%0d valid=%b",
                         i, g3, b3, v3, e.g[2:0], e.b, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_lock();
        test_drop_wrap();
        test_enable();
        test_sole_requester();
        test_async_reset();
        test_n3_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Registered round-robin arbiter with packet lock for the NoC switch allocator. It accepts per-port requests and issues a one-hot grant that is held for a whole packet. The grant drives the one-hot crossbar multiplexer select directly. A binary copy of the grant index is produced for the credit and port-tracking logic. Fairness comes from a rotating priority pointer: the last-served port always has the lowest priority.

## Interface
- `ARBITER_WIDTH`, default 4: number of requesting ports (N), 2..16.
- `BIN_WIDTH`, default ceil(log2(ARBITER_WIDTH)), minimum 1: width of the binary grant index.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `request`: input, N bits. Per-port request; bit i high means port i has a flit waiting.
- `release`: input, 1 bit. The tail flit of the currently granted port transfers this cycle.
- `en`: input, 1 bit. Allocation enable; when low, no new grant is issued.
- `grant`: output, N bits. Registered one-hot grant; all zeros when idle.
- `grant_bin`: output, BIN_WIDTH bits. Registered binary index of `grant`; 0 when idle.
- `grant_valid`: output, 1 bit. Registered; equals OR of `grant`.

## Operation
- State machine has two states:
  - IDLE: `grant_valid`=0.
  - LOCKED: `grant_valid`=1, exactly one `grant` bit set.
- Priority pointer `ptr` (BIN_WIDTH bits) names the highest-priority port.
  - Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, wrapping modulo N (not modulo 2^BIN_WIDTH).
- Arbitration event: the winner is the first requesting port in search order. On the edge, the arbiter performs all of the following:
  - loads `grant` with the winner's one-hot;
  - loads `grant_bin` with the winner's index;
  - sets `ptr` = (winner+1) mod N;
  - enters LOCKED.
- IDLE → LOCKED: at an edge where `en`=1 and `request`≠0.
- IDLE stays IDLE if `en`=0 or `request`=0. `ptr` is unchanged.
- LOCKED hold: the grant is unchanged while `request[g]`=1 and `release`=0, regardless of `en` or other requests.
- LOCKED end condition: at an edge where `release`=1 or `request[g]`=0.
  - With `en`=1 and some request present (the just-released port included), perform an arbitration event in the same edge. This gives back-to-back grants with no idle bubble.
  - Otherwise → IDLE, with `grant`=0 and `grant_bin`=0.
- The released port has the lowest priority in the re-arbitration because `ptr` already points past it. It wins again only if it is the sole requester.
- `release` while in IDLE is ignored.
- Requests on port indices ≥ N do not exist. `ptr` never takes a value ≥ N.
- Reset: `grant`=0, `grant_bin`=0, `grant_valid`=0, `ptr`=0, state IDLE, all immediately on `rst_n` falling, independent of `clk`.
  - Reset mid-packet drops the lock.
  - The first edge after `rst_n` rises arbitrates with port 0 highest.

## Timing
- Request-to-grant latency: `request` sampled at edge k gives `grant` valid after edge k (one cycle); there is no combinational path from inputs to outputs.
- `release` sampled at edge k: the old grant is visible through cycle k; the new grant (or zero) appears after edge k.
- `grant`, `grant_bin`, and `grant_valid` change together on the same edge. They are always mutually consistent, and `grant` never has more than one bit set.
- Lock duration is at least one cycle. A single-flit packet has `release`=1 in the grant's first cycle.

## Test plan
- Reset/idle, N=4: hold `rst_n`=0 with `request`=4'b1111 → `grant`=0, `grant_bin`=0, `grant_valid`=0. Release reset, `en`=1 → after first edge `grant`=4'b0001, `grant_bin`=0.
- Round-robin rotation: `request`=4'b1111, `en`=1, `release` pulsed every cycle → grants cycle 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no idle gap.
- Packet lock: port 2 granted, `request` changes to 4'b1111 for 5 cycles with `release`=0 → `grant` stays 4'b0100. `release`=1 → next grant 4'b1000, `grant_bin`=3.
- Request drop and wrap: port 3 locked, `request[3]` falls, `request`=4'b0001 → next `grant`=4'b0001. Then `request`=0 with `release`=1 → IDLE, `grant_valid`=0.
- Enable gating: IDLE, `en`=0, `request`=4'b0010 for 3 cycles → no grant. Raise `en` → `grant`=4'b0010 one cycle later. During LOCKED, `en`=0 → grant held until release, then IDLE.
- Async reset mid-packet: port 1 locked, pull `rst_n` low between clock edges → outputs zero before the next edge, `ptr`=0. Non-power-of-two N=3, all requesting with release every cycle → grant sequence 001, 010, 100, 001 (no index 3).
